// File: rtl/seat_request_ctrl.sv
// Front-end sequencer for the seat reservation table: kiosk request FIFO,
// manager command register, minute clock and one-pulse-at-a-time command issue.

package seat_request_ctrl_pkg;

    localparam int unsigned STUDENT_W = 32;
    localparam int unsigned SEAT_W    = 5;
    localparam int unsigned SSTATE_W  = 2;
    localparam int unsigned MINUTE_W  = 11;

    typedef struct packed {
        logic [STUDENT_W-1:0] student;
        logic [SEAT_W-1:0]    seat;
        logic [SSTATE_W-1:0]  state;
    } seat_req_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_BAN   = 2'd1,
        OP_LIMIT = 2'd2,
        OP_CLEAR = 2'd3
    } mgr_op_e;

endpackage

module seat_request_ctrl
    import seat_request_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned TICKS_PER_MIN = 60,
    parameter int unsigned LIMIT_DEFAULT = 120,
    parameter int unsigned BAN_DEFAULT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [STUDENT_W-1:0] req_student,
    input  logic [SEAT_W-1:0]    req_seat,
    input  logic [SSTATE_W-1:0]  req_state,
    input  logic                 mgr_valid,
    input  logic [1:0]           mgr_op,
    input  logic [1:0]           mgr_ban,
    input  logic [MINUTE_W-1:0]  mgr_limit,
    output logic                 rst_mem,
    output logic                 write_mem,
    output logic [STUDENT_W-1:0] Student_No_mem,
    output logic [SEAT_W-1:0]    Seat_No_mem,
    output logic [SSTATE_W-1:0]  Seat_State_mem,
    output logic [MINUTE_W-1:0]  Time_mem,
    output logic [1:0]           write_set_mem,
    output logic [1:0]           ban_mem,
    output logic [MINUTE_W-1:0]  limit_time_mem,
    output logic [2:0]           fifo_count,
    output logic [7:0]           drop_cnt
);

    localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TICK_W      = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam int unsigned MIN_PER_DAY = 1440;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;

    seat_req_t             r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_pend_vld;
    mgr_op_e               r_pend_op;
    logic [1:0]            r_pend_ban;
    logic [MINUTE_W-1:0]   r_pend_limit;

    logic [TICK_W-1:0]     r_tick;
    logic [MINUTE_W-1:0]   r_time;

    seat_req_t             r_ops;
    seat_req_t             w_ops_nxt;
    logic                  r_write;
    logic                  w_write_nxt;
    logic                  r_rst;
    logic                  w_rst_nxt;
    logic [1:0]            r_set;
    logic [1:0]            w_set_nxt;
    logic [1:0]            r_ban;
    logic [1:0]            w_ban_nxt;
    logic [MINUTE_W-1:0]   r_limit;
    logic [MINUTE_W-1:0]   w_limit_nxt;
    logic [7:0]            r_drop;

    logic                  w_req_ready;
    logic                  w_req_ok;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_take_mgr;
    logic                  w_flush;
    logic                  w_mgr_load;

    assign w_req_ready = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_req_ok    = (req_student != '0) && (req_state != 2'd3);
    assign w_accept    = req_valid && w_req_ready;
    // A push landing on the clear-all edge is discarded along with the queue.
    assign w_push      = w_accept && w_req_ok && !w_flush;
    assign w_drop      = w_accept && !w_req_ok;
    assign w_mgr_load  = mgr_valid && (mgr_op != 2'd0);

    // Free-running minute-of-day clock, independent of the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
            r_time <= '0;
        end else if (r_tick == TICK_W'(TICKS_PER_MIN - 1)) begin
            r_tick <= '0;
            r_time <= (r_time == MINUTE_W'(MIN_PER_DAY - 1)) ? '0 : r_time + MINUTE_W'(1);
        end else begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    // Kiosk request queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{student: req_student, seat: req_seat, state: req_state};
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Saturating count of rejected requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // Single-entry manager command register; a newer command replaces an older one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld   <= 1'b0;
            r_pend_op    <= OP_NOP;
            r_pend_ban   <= '0;
            r_pend_limit <= '0;
        end else if (w_mgr_load) begin
            r_pend_vld   <= 1'b1;
            r_pend_op    <= mgr_op_e'(mgr_op);
            r_pend_ban   <= (mgr_ban == 2'd3) ? 2'd2 : mgr_ban;
            r_pend_limit <= mgr_limit;
        end else if (w_take_mgr) begin
            r_pend_vld   <= 1'b0;
        end
    end

    // Sequencer state and registered table-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_rst   <= 1'b0;
            r_set   <= '0;
            r_ops   <= '0;
            r_ban   <= 2'(BAN_DEFAULT);
            r_limit <= MINUTE_W'(LIMIT_DEFAULT);
        end else begin
            r_state <= w_state_nxt;
            r_write <= w_write_nxt;
            r_rst   <= w_rst_nxt;
            r_set   <= w_set_nxt;
            r_ops   <= w_ops_nxt;
            r_ban   <= w_ban_nxt;
            r_limit <= w_limit_nxt;
        end
    end

    // Next-state: manager command beats the queue; each operation spends ISSUE then HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_take_mgr  = 1'b0;
        w_flush     = 1'b0;
        w_write_nxt = 1'b0;
        w_rst_nxt   = 1'b0;
        w_set_nxt   = '0;
        w_ops_nxt   = r_ops;
        w_ban_nxt   = r_ban;
        w_limit_nxt = r_limit;

        unique case (r_state)
            ST_IDLE: begin
                if (r_pend_vld) begin
                    w_take_mgr  = 1'b1;
                    w_state_nxt = ST_ISSUE;
                    case (r_pend_op)
                        OP_BAN: begin
                            w_ban_nxt = r_pend_ban;
                            w_set_nxt = 2'd1;
                        end
                        OP_LIMIT: begin
                            w_limit_nxt = r_pend_limit;
                            w_set_nxt   = 2'd2;
                        end
                        OP_CLEAR: begin
                            w_rst_nxt = 1'b1;
                            w_flush   = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_write_nxt = 1'b1;
                    w_ops_nxt   = r_fifo[r_rd_ptr];
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_HOLD;
            ST_HOLD:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready      = w_req_ready;
    assign rst_mem        = r_rst;
    assign write_mem      = r_write;
    assign Student_No_mem = r_ops.student;
    assign Seat_No_mem    = r_ops.seat;
    assign Seat_State_mem = r_ops.state;
    assign Time_mem       = r_time;
    assign write_set_mem  = r_set;
    assign ban_mem        = r_ban;
    assign limit_time_mem = r_limit;
    assign fifo_count     = 3'(r_count);
    assign drop_cnt       = r_drop;

endmodule

// File: tb/tb_seat_request_ctrl.sv
// Bench for seat_request_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a timestamp-based model of the issue schedule.

module tb_seat_request_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TPM   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_student = '0;
    logic [4:0]  req_seat = '0;
    logic [1:0]  req_state = '0;
    logic        mgr_valid = 1'b0;
    logic [1:0]  mgr_op = '0;
    logic [1:0]  mgr_ban = '0;
    logic [10:0] mgr_limit = '0;
    logic        rst_mem;
    logic        write_mem;
    logic [31:0] Student_No_mem;
    logic [4:0]  Seat_No_mem;
    logic [1:0]  Seat_State_mem;
    logic [10:0] Time_mem;
    logic [1:0]  write_set_mem;
    logic [1:0]  ban_mem;
    logic [10:0] limit_time_mem;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    seat_request_ctrl #(
        .FIFO_DEPTH(DEPTH), .TICKS_PER_MIN(TPM), .LIMIT_DEFAULT(120), .BAN_DEFAULT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_student(req_student),
        .req_seat(req_seat), .req_state(req_state),
        .mgr_valid(mgr_valid), .mgr_op(mgr_op), .mgr_ban(mgr_ban), .mgr_limit(mgr_limit),
        .rst_mem(rst_mem), .write_mem(write_mem), .Student_No_mem(Student_No_mem),
        .Seat_No_mem(Seat_No_mem), .Seat_State_mem(Seat_State_mem), .Time_mem(Time_mem),
        .write_set_mem(write_set_mem), .ban_mem(ban_mem), .limit_time_mem(limit_time_mem),
        .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of requests, a pending command, and the earliest edge at which
    // the next table operation may start (each operation occupies three edges).
    typedef struct packed {
        logic [31:0] stu;
        logic [4:0]  seat;
        logic [1:0]  st;
    } ent_t;

    ent_t        q[$];
    bit          p_vld = 1'b0;
    logic [1:0]  p_op = '0;
    logic [1:0]  p_ban = '0;
    logic [10:0] p_lim = '0;
    int          edge_i = 0;
    int          next_free = 0;
    int          m_ticks = 0;
    int          m_drop = 0;
    bit          m_write = 1'b0;
    bit          m_rst = 1'b0;
    logic [1:0]  m_set = '0;
    logic [31:0] m_stu = '0;
    logic [4:0]  m_seat = '0;
    logic [1:0]  m_sst = '0;
    logic [1:0]  m_ban = 2'd2;
    logic [10:0] m_limit = 11'd120;

    task m_reset();
        q.delete();
        p_vld = 1'b0; edge_i = 0; next_free = 0; m_ticks = 0; m_drop = 0;
        m_write = 1'b0; m_rst = 1'b0; m_set = '0;
        m_stu = '0; m_seat = '0; m_sst = '0; m_ban = 2'd2; m_limit = 11'd120;
    endtask

    task m_step();
        bit   rdy;
        bit   flush;
        bit   took;
        ent_t e;
        rdy = (q.size() < DEPTH);
        flush = 1'b0;
        took = 1'b0;
        m_write = 1'b0; m_rst = 1'b0; m_set = '0;
        if (edge_i >= next_free) begin
            if (p_vld) begin
                took = 1'b1;
                next_free = edge_i + 3;
                if (p_op == 2'd1) begin m_ban = p_ban; m_set = 2'd1; end
                else if (p_op == 2'd2) begin m_limit = p_lim; m_set = 2'd2; end
                else if (p_op == 2'd3) begin m_rst = 1'b1; flush = 1'b1; q.delete(); end
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_write = 1'b1; m_stu = e.stu; m_seat = e.seat; m_sst = e.st;
                next_free = edge_i + 3;
            end
        end
        if (mgr_valid && mgr_op != 2'd0) begin
            p_vld = 1'b1; p_op = mgr_op; p_lim = mgr_limit;
            p_ban = (mgr_ban == 2'd3) ? 2'd2 : mgr_ban;
        end else if (took) begin
            p_vld = 1'b0;
        end
        if (req_valid && rdy) begin
            if (req_student == 0 || req_state == 2'd3) begin
                if (m_drop < 255) m_drop++;
            end else if (!flush) begin
                q.push_back('{stu: req_student, seat: req_seat, st: req_state});
            end
        end
        m_ticks++;
        edge_i++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    // Per-cycle comparison of every output against the model.
    always begin
        @(posedge clk);
        #3;
        chk("req_ready", req_ready, (q.size() < DEPTH));
        chk("write_mem", write_mem, m_write);
        chk("rst_mem", rst_mem, m_rst);
        chk("write_set_mem", write_set_mem, m_set);
        chk("Student_No_mem", Student_No_mem, m_stu);
        chk("Seat_No_mem", Seat_No_mem, m_seat);
        chk("Seat_State_mem", Seat_State_mem, m_sst);
        chk("Time_mem", Time_mem, (m_ticks / TPM) % 1440);
        chk("ban_mem", ban_mem, m_ban);
        chk("limit_time_mem", limit_time_mem, m_limit);
        chk("fifo_count", fifo_count, q.size());
        chk("drop_cnt", drop_cnt, m_drop);
    end

    task automatic idle();
        req_valid = 1'b0; req_student = '0; req_seat = '0; req_state = '0;
        mgr_valid = 1'b0; mgr_op = '0; mgr_ban = '0; mgr_limit = '0;
    endtask

    task automatic push(input logic [31:0] s, input logic [4:0] seat, input logic [1:0] st);
        req_valid = 1'b1; req_student = s; req_seat = seat; req_state = st;
    endtask

    task automatic mgr(input logic [1:0] op, input logic [1:0] ban, input logic [10:0] lim);
        mgr_valid = 1'b1; mgr_op = op; mgr_ban = ban; mgr_limit = lim;
    endtask

    initial begin
        int k;
        idle();
        repeat (3) @(posedge clk);
        #3;
        chk("reset_ban", ban_mem, 2);
        chk("reset_limit", limit_time_mem, 120);
        chk("reset_ready", req_ready, 1);
        chk("reset_write", write_mem, 0);
        chk("reset_time", Time_mem, 0);
        @(negedge clk); rst_n = 1'b1;

        // Single request: write pulse two edges after the push.
        @(negedge clk); push(32'd1234, 5'd5, 2'd1);
        @(negedge clk); idle();
        @(posedge clk); #3;
        chk("t1_write", write_mem, 1);
        chk("t1_student", Student_No_mem, 1234);
        chk("t1_seat", Seat_No_mem, 5);
        chk("t1_state", Seat_State_mem, 1);
        @(posedge clk); #3;
        chk("t1_write_end", write_mem, 0);
        chk("t1_count", fifo_count, 0);
        repeat (6) @(posedge clk);

        // Five back-to-back requests while manager commands keep the table busy.
        @(negedge clk); push(32'd101, 5'd1, 2'd1); mgr(2'd1, 2'd1, 11'd0);
        @(negedge clk); push(32'd102, 5'd2, 2'd2); mgr(2'd1, 2'd0, 11'd0);
        @(negedge clk); push(32'd103, 5'd3, 2'd0); mgr_valid = 1'b0;
        @(negedge clk); push(32'd104, 5'd4, 2'd1);
        @(posedge clk); #3;
        chk("t2_full_count", fifo_count, 4);
        chk("t2_not_ready", req_ready, 0);
        @(negedge clk); push(32'd105, 5'd31, 2'd2);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t2_r5_accept_wait", int'(k < 20), 1);
        @(negedge clk); idle();
        repeat (40) @(posedge clk);

        // Invalid requests are dropped, and the drop counter saturates.
        @(negedge clk); push(32'd0, 5'd1, 2'd1);
        @(negedge clk); push(32'd77, 5'd1, 2'd3);
        @(negedge clk); idle();
        @(posedge clk); #3;
        chk("t3_drop2", drop_cnt, 2);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); push(32'd0, 5'(i), 2'd1);
        end
        @(negedge clk); idle();
        @(posedge clk); #3;
        chk("t3_drop_sat", drop_cnt, 255);

        // Limit update overtakes two queued requests.
        @(negedge clk); push(32'd201, 5'd7, 2'd1); mgr(2'd2, 2'd0, 11'd30);
        @(negedge clk); push(32'd202, 5'd8, 2'd2); mgr_valid = 1'b0;
        @(negedge clk);
        chk("t4_set_limit", write_set_mem, 2);
        chk("t4_limit", limit_time_mem, 30);
        chk("t4_count", fifo_count, 2);
        chk("t4_no_write", write_mem, 0);
        idle();
        repeat (20) @(posedge clk);

        // Clear-all with three queued; a push on the flush edge is lost.
        @(negedge clk); push(32'd301, 5'd1, 2'd1); mgr(2'd1, 2'd3, 11'd0);
        @(negedge clk); push(32'd302, 5'd2, 2'd1); mgr_valid = 1'b0;
        @(negedge clk); push(32'd303, 5'd3, 2'd1); mgr(2'd3, 2'd0, 11'd0);
        @(negedge clk); idle();
        @(negedge clk); push(32'd304, 5'd4, 2'd1);
        @(negedge clk);
        chk("t5_rst_mem", rst_mem, 1);
        chk("t5_flushed", fifo_count, 0);
        chk("t5_ban_none", ban_mem, 2);
        chk("t5_drop_kept", drop_cnt, 255);
        idle();
        repeat (20) @(posedge clk);

        // Random traffic.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req_valid   = 1'($urandom_range(0, 1));
            req_student = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            req_seat    = 5'($urandom);
            req_state   = 2'($urandom);
            mgr_valid   = ($urandom_range(0, 15) == 0);
            mgr_op      = 2'($urandom);
            mgr_ban     = 2'($urandom);
            mgr_limit   = 11'($urandom);
        end
        @(negedge clk); idle();

        // Day wrap of the minute clock, then reset during an ISSUE cycle.
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2879) @(posedge clk);
        #3;
        chk("t6_time_1439", Time_mem, 1439);
        @(posedge clk); #3;
        chk("t6_time_wrap", Time_mem, 0);
        @(negedge clk); push(32'd555, 5'd9, 2'd2);
        @(negedge clk); idle();
        k = 0;
        do begin
            @(posedge clk); #3;
            k++;
        end while (!write_mem && k < 10);
        chk("t6_issue_seen", write_mem, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_write", write_mem, 0);
        chk("t6_rst_time", Time_mem, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_student", Student_No_mem, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seat_request_ctrl.md
# seat_request_ctrl

Front-end sequencer for the seat reservation table. It accepts student kiosk requests through a valid/ready handshake into a small FIFO, accepts manager commands, and keeps the time-of-day minute clock. It drives the seat table's command inputs with one-cycle write pulses and stable operands, so the table never sees overlapping writes.

## Interface
Parameters:
- FIFO_DEPTH, 4: kiosk request queue entries (power of 2).
- TICKS_PER_MIN, 60: clk cycles per simulated minute.
- LIMIT_DEFAULT, 120: reset value of limit_time_mem (minutes).
- BAN_DEFAULT, 2: reset value of ban_mem (2 = no ban).

Ports:
- clk  in  1  sole clock; everything on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  kiosk request present.
- req_ready  out  1  queue can accept; equals (count < FIFO_DEPTH).
- req_student  in  32  student number.
- req_seat  in  5  seat index 0..31.
- req_state  in  2  requested state (0 check-out, 1 reserve, 2 in-use).
- mgr_valid  in  1  one-cycle manager command strobe.
- mgr_op  in  2  0 nop, 1 set ban, 2 set limit, 3 clear all.
- mgr_ban  in  2  ban parity (0 even, 1 odd, 2 none).
- mgr_limit  in  11  limit time in minutes.
- rst_mem  out  1  table clear pulse.
- write_mem  out  1  seat write pulse.
- Student_No_mem  out  32  operand.
- Seat_No_mem  out  5  operand.
- Seat_State_mem  out  2  operand.
- Time_mem  out  11  minutes since midnight, 0..1439.
- write_set_mem  out  2  1 = ban update pulse, 2 = limit update pulse, 0 otherwise.
- ban_mem  out  2  current ban setting.
- limit_time_mem  out  11  current limit.
- fifo_count  out  3  queued requests.
- drop_cnt  out  8  rejected requests, saturating.

## Operation
- Reset values: all outputs 0, except ban_mem = BAN_DEFAULT, limit_time_mem = LIMIT_DEFAULT, and req_ready = 1.
- Minute clock:
  - A tick counter runs 0..TICKS_PER_MIN-1.
  - On wrap, Time_mem increments; 1439 wraps to 0.
  - Time_mem runs continuously and is never paused by the FSM.
- Request intake:
  - A push happens when req_valid && req_ready at an edge.
  - A request is validated at push time. If req_student == 0 or req_state == 3, it is not queued and drop_cnt increments (saturates at 255).
  - Otherwise {student, seat, state} is pushed.
- Manager intake:
  - mgr_valid with mgr_op != 0 loads a 1-entry pending register. A later command overwrites it (last wins).
  - mgr_ban == 3 is stored as 2.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: if a manager command is pending, go to ISSUE with that command; else if fifo_count > 0, pop the head and go to ISSUE; else stay in IDLE.
  - ISSUE: exactly one cycle.
    - Request: write_mem = 1 with operands from the popped entry.
    - Set ban: ban_mem is updated on entry to ISSUE and write_set_mem = 1.
    - Set limit: limit_time_mem is updated on entry to ISSUE and write_set_mem = 2.
    - Clear all: rst_mem = 1 and the FIFO is flushed. Flushed entries do not count as drops.
  - HOLD: one cycle with all pulses at 0; operands hold their ISSUE values. Then go to IDLE.
- Priority: a manager command always beats the queue. Queued requests are never reordered.

## Timing
- Push at edge N into an empty queue with the FSM in IDLE: pop at edge N+1, write_mem high from edge N+1 to edge N+2.
- Maximum throughput is one table operation per 3 cycles.
- Pulses (write_mem, rst_mem, write_set_mem != 0) are mutually exclusive and last exactly 1 cycle.
- Operand outputs are registered and stable from the pulse's rising edge through the end of HOLD.
- Simultaneous push and pop:
  - When not full, both occur and fifo_count is unchanged.
  - When full, req_ready is already 0, so no push occurs.
- Clear-all and push in the same cycle as the flush edge: the push is discarded.
- Time_mem sampled by the table is whatever the counter shows during ISSUE; it is not latched at push time.
- rst_n assertion mid-operation: immediately clears the FIFO, the pending command and the FSM (to IDLE), and sets all outputs to their reset values. The pulse in flight is truncated.

## Test plan
- Reset, push {1234, seat 5, state 1} → write_mem high for 1 cycle, two edges after push; Student_No_mem = 1234, Seat_No_mem = 5, Seat_State_mem = 1; fifo_count returns to 0.
- Push 5 requests back-to-back with FIFO_DEPTH = 4 and the FSM blocked by a pending manager command → req_ready drops at count 4; all accepted requests issue in order, 3 cycles apart.
- Push student 0, then state 3 → neither issues, drop_cnt = 2; push 256 invalid requests → drop_cnt holds at 255.
- mgr set limit 30 while 2 requests are queued → write_set_mem = 2 and limit_time_mem = 30 before either write_mem pulse.
- mgr clear-all with 3 queued → one rst_mem pulse, fifo_count = 0, no write_mem pulses, drop_cnt unchanged.
- With TICKS_PER_MIN = 2, run 2880 cycles → Time_mem goes 1439 → 0; assert rst_n low during an ISSUE cycle → write_mem falls immediately and Time_mem = 0.
